// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- receive-side byte bus of the UART receiver.
//
// Signals
//   uart_data_vld : one-cycle strobe, a freshly received byte is on uart_data
//   uart_data     : last correctly received byte, held until the next one
//   frame_err     : one-cycle strobe, the stop bit was sampled low
//
// Modports
//   master : the receiver that produces the bus (uart_rx)
//   slave  : the downstream consumer (command decoder, testbench)
//
// There is no back-pressure: the consumer takes uart_data on the strobe cycle.
// ---------------------------------------------------------------------------
interface uart_rx_if;

    logic       uart_data_vld;
    logic [7:0] uart_data;
    logic       frame_err;

    modport master (
        output uart_data_vld,
        output uart_data,
        output frame_err
    );

    modport slave (
        input uart_data_vld,
        input uart_data,
        input frame_err
    );

endinterface : uart_rx_if

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 asynchronous serial receiver, LSB first, idle-high line.
//
// Parameters
//   CLK_FREQ  : system clock frequency in Hz
//   BAUD_RATE : serial bit rate in bit/s
//
// Ports
//   clk      : system clock, all state changes on its rising edge
//   rst_n    : asynchronous active-low reset
//   rs232_rx : asynchronous serial input line
//   rx_if    : uart_rx_if.master -- uart_data_vld / uart_data / frame_err
//
// Operation
//   The line is synchronised through two flops and a third stage provides a
//   falling-edge detector. A start edge seen in IDLE launches a free-running
//   baud counter; every decision (start check, each data bit, stop bit) is
//   taken when the counter hits the middle of a bit period. A good stop bit
//   publishes the byte and returns to IDLE half-way through the stop bit, so
//   back-to-back frames are never missed. A low stop bit flags frame_err and
//   waits in ERR_WAIT until the line is released (break tolerance).
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rs232_rx,
    uart_rx_if.master rx_if
);

    // -----------------------------------------------------------------------
    // Baud timing constants
    // -----------------------------------------------------------------------
    localparam int BAUD_CNT_END = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_CNT_MID = BAUD_CNT_END / 2;
    // Smallest width that can hold BAUD_CNT_END-1.
    localparam int CNT_W        = (BAUD_CNT_END > 1) ? $clog2(BAUD_CNT_END) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_END - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MID);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        ERR_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    // Synchroniser / edge-detector stages
    logic rx_s1;
    logic rx_s2;
    logic rx_s3;
    logic fall_edge;

    // Datapath
    logic [CNT_W-1:0] baud_cnt;
    logic             mid_hit;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       data_q;
    logic             vld_q;
    logic             err_q;

    // Control decoded from the current state
    logic cnt_run;
    logic enter_data;
    logic sample_bit;
    logic load_byte;
    logic flag_err;

    // -----------------------------------------------------------------------
    // Input synchroniser and falling-edge detector. All stages reset to the
    // idle line level so that reset release never fakes a start edge.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours; blocking assignments
    // here would collapse the three-stage chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rs232_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign fall_edge = rx_s3 & ~rx_s2;
    assign mid_hit   = (baud_cnt == CNT_MID);

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic. Edges only matter in IDLE; in every
    // other state the line is looked at only at mid-bit (or, in ERR_WAIT,
    // for the released level).
    // -----------------------------------------------------------------------
    // NOTE: the default assignment at the top of each always_comb gives every
    // path a value, which is what keeps these blocks from inferring latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    state_next = START;
                end
            end
            START: begin
                // A line already high again at mid-start-bit was a glitch.
                if (mid_hit) begin
                    state_next = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid_hit && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so the next start edge is caught even
                // with zero idle time between frames.
                if (mid_hit) begin
                    state_next = rx_s2 ? IDLE : ERR_WAIT;
                end
            end
            ERR_WAIT: begin
                // Stay put through a break until the line is released.
                if (rx_s2) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: control outputs decoded from the current state
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_run    = 1'b0;
        enter_data = 1'b0;
        sample_bit = 1'b0;
        load_byte  = 1'b0;
        flag_err   = 1'b0;
        case (state)
            START: begin
                cnt_run    = 1'b1;
                enter_data = mid_hit & ~rx_s2;
            end
            DATA: begin
                cnt_run    = 1'b1;
                sample_bit = mid_hit;
            end
            STOP: begin
                cnt_run    = 1'b1;
                load_byte  = mid_hit &  rx_s2;
                flag_err   = mid_hit & ~rx_s2;
            end
            default: begin
                cnt_run    = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Baud counter: free-running 0..END-1 across START/DATA/STOP, held at 0
    // otherwise. Holding it at 0 in IDLE is what clears it on the start edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (!cnt_run || (baud_cnt == CNT_LAST)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Bit index and shift register. Bits arrive LSB first, so each sample is
    // shifted in from the top and bit 0 ends up in shift_reg[0].
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if (enter_data) begin
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample_bit) begin
                shift_reg <= {rx_s2, shift_reg[7:1]};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs. uart_data only changes on a good frame; both
    // strobes come from single-cycle mid-stop-bit conditions, so they are
    // mutually exclusive and never last longer than one clock.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            vld_q <= load_byte;
            err_q <= flag_err;
            if (load_byte) begin
                data_q <= shift_reg;
            end
        end
    end

    assign rx_if.uart_data_vld = vld_q;
    assign rx_if.uart_data     = data_q;
    assign rx_if.frame_err     = err_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// Three receivers share clk/rst_n, each with its own serial line:
//   inst 0 : default parameters (50 MHz / 9600 -> 5208 clk per bit)
//   inst 1 : 25.6 MHz / 100000 -> 256 clk per bit (most directed scenarios)
//   inst 2 : 1 MHz / 115200 -> 8 clk per bit
// The frame driver pushes the expected strobe (kind, byte, latency) into a
// per-instance queue; a negedge monitor pops and compares on every strobe.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DEF_END  = 50_000_000 / 9600;
    localparam int MID_END  = 25_600_000 / 100_000;
    localparam int FAST_END = 1_000_000 / 115200;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         start_cyc;
        int         lat;
    } exp_t;

    logic clk;
    logic rst_n = 1'b0;
    logic rx_def = 1'b1;
    logic rx_mid = 1'b1;
    logic rx_fast = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t       q_def[$];
    exp_t       q_mid[$];
    exp_t       q_fast[$];
    logic [7:0] last_good[3];
    bit         prev_stb[3];

    uart_rx_if if_def ();
    uart_rx_if if_mid ();
    uart_rx_if if_fast ();

    uart_rx u_def (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (rx_def),
        .rx_if    (if_def)
    );

    uart_rx #(
        .CLK_FREQ  (25_600_000),
        .BAUD_RATE (100_000)
    ) u_mid (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (rx_mid),
        .rx_if    (if_mid)
    );

    uart_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (115200)
    ) u_fast (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (rx_fast),
        .rx_if    (if_fast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_line(input int inst, input logic v);
        case (inst)
            0:       rx_def  = v;
            1:       rx_mid  = v;
            default: rx_fast = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Must be called on a negedge; returns on a negedge with the line left at
    // the stop-bit level.
    task automatic send_frame(input int inst, input logic [7:0] data,
                              input bit good_stop, input int end_clks);
        exp_t e;
        e.is_err    = !good_stop;
        e.data      = good_stop ? data : last_good[inst];
        e.start_cyc = cyc;
        e.lat       = 3 + 9 * end_clks + end_clks / 2;
        case (inst)
            0:       q_def.push_back(e);
            1:       q_mid.push_back(e);
            default: q_fast.push_back(e);
        endcase
        if (good_stop) last_good[inst] = data;
        drive_line(inst, 1'b0);
        idle(end_clks);
        for (int i = 0; i < 8; i++) begin
            drive_line(inst, data[i]);
            idle(end_clks);
        end
        drive_line(inst, good_stop);
        idle(end_clks);
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard monitor (outputs sampled on the falling edge)
    // -----------------------------------------------------------------------
    task automatic monitor(input int inst, input logic vld, input logic err,
                           input logic [7:0] data);
        exp_t e;
        bit   have;
        bit   stb;
        int   lat;
        stb  = (vld === 1'b1) || (err === 1'b1);
        have = 1'b0;
        if (prev_stb[inst]) begin
            total++;
            assert (stb == 1'b0) else begin
                bad++;
                $error("FAIL strobe_width inst=%0d observed vld=%b err=%b expected both low", inst, vld, err);
            end
        end
        if (stb) begin
            case (inst)
                0:       if (q_def.size()  > 0) begin e = q_def.pop_front();  have = 1'b1; end
                1:       if (q_mid.size()  > 0) begin e = q_mid.pop_front();  have = 1'b1; end
                default: if (q_fast.size() > 0) begin e = q_fast.pop_front(); have = 1'b1; end
            endcase
            total++;
            assert (have) else begin
                bad++;
                $error("FAIL unexpected_strobe inst=%0d observed vld=%b err=%b data=%h expected no strobe", inst, vld, err, data);
            end
            if (have) begin
                total++;
                assert ({vld, err} === (e.is_err ? 2'b01 : 2'b10)) else begin
                    bad++;
                    $error("FAIL strobe_kind inst=%0d observed vld/err=%b%b expected %s", inst, vld, err, e.is_err ? "frame_err" : "vld");
                end
                total++;
                assert (data === e.data) else begin
                    bad++;
                    $error("FAIL strobe_data inst=%0d observed=%h expected=%h", inst, data, e.data);
                end
                lat = cyc - e.start_cyc;
                total++;
                assert ((lat >= e.lat - 1) && (lat <= e.lat + 1)) else begin
                    bad++;
                    $error("FAIL strobe_latency inst=%0d observed=%0d expected=%0d+/-1", inst, lat, e.lat);
                end
            end
        end
        prev_stb[inst] = stb;
    endtask

    always @(negedge clk) begin
        monitor(0, if_def.uart_data_vld,  if_def.frame_err,  if_def.uart_data);
        monitor(1, if_mid.uart_data_vld,  if_mid.frame_err,  if_mid.uart_data);
        monitor(2, if_fast.uart_data_vld, if_fast.frame_err, if_fast.uart_data);
    end

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [7:0] partial;
        for (int i = 0; i < 3; i++) last_good[i] = 8'h00;

        // Reset state, with the clock running
        idle(3);
        chk("rst_def_vld",  {7'd0, if_def.uart_data_vld}, 8'h00);
        chk("rst_def_err",  {7'd0, if_def.frame_err},     8'h00);
        chk("rst_def_data", if_def.uart_data,             8'h00);
        chk("rst_mid_vld",  {7'd0, if_mid.uart_data_vld}, 8'h00);
        chk("rst_mid_data", if_mid.uart_data,             8'h00);
        chk("rst_fast_data", if_fast.uart_data,           8'h00);
        rst_n = 1'b1;
        idle(4);

        // Single frame at default parameters
        send_frame(0, 8'h55, 1'b1, DEF_END);
        idle(16);

        // Back-to-back frames, no idle gap
        send_frame(1, 8'hAA, 1'b1, MID_END);
        send_frame(1, 8'h55, 1'b1, MID_END);
        idle(MID_END);

        // 100-clk low glitch (shorter than half a bit), then a real frame
        rx_mid = 1'b0;
        idle(100);
        rx_mid = 1'b1;
        idle(2 * MID_END);
        send_frame(1, 8'h3C, 1'b1, MID_END);
        idle(MID_END);

        // Stop bit low, line held low for 3 bit times, then recovery
        send_frame(1, 8'hFF, 1'b0, MID_END);
        idle(MID_END);
        chk("err_hold_data", if_mid.uart_data, 8'h3C);
        idle(2 * MID_END);
        rx_mid = 1'b1;
        idle(2 * MID_END);
        send_frame(1, 8'h12, 1'b1, MID_END);
        idle(MID_END);

        // Reset pulse in data bit 4 of 0x99; that frame is abandoned
        partial = 8'h99;
        rx_mid  = 1'b0;
        idle(MID_END);
        for (int i = 0; i < 4; i++) begin
            rx_mid = partial[i];
            idle(MID_END);
        end
        rx_mid = partial[4];
        idle(MID_END / 2);
        rst_n = 1'b0;
        idle(3);
        chk("midrst_vld",  {7'd0, if_mid.uart_data_vld}, 8'h00);
        chk("midrst_err",  {7'd0, if_mid.frame_err},     8'h00);
        chk("midrst_data", if_mid.uart_data,             8'h00);
        for (int i = 0; i < 3; i++) last_good[i] = 8'h00;
        rx_mid = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(2 * MID_END);
        send_frame(1, 8'hA5, 1'b1, MID_END);
        idle(MID_END);

        // Eight clocks per bit
        send_frame(2, 8'hC3, 1'b1, FAST_END);
        idle(4 * FAST_END);

        // Every expected strobe must have appeared
        chk("pending_def",  8'(q_def.size()),  8'h00);
        chk("pending_mid",  8'(q_mid.size()),  8'h00);
        chk("pending_fast", 8'(q_fast.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rs232_rx  input  1  asynchronous serial line; idle high, 8N1 framing, LSB first.
REQ-006 SHALL have port uart_data_vld  output  1  one-cycle strobe; a valid byte is on uart_data.
REQ-007 SHALL have port uart_data  output  8  last correctly received byte; held until the next valid byte.
REQ-008 SHALL have port frame_err  output  1  one-cycle strobe; stop bit was sampled low.

Function
REQ-009 SHALL derive BAUD_CNT_END = CLK_FREQ/BAUD_RATE (integer division) and BAUD_CNT_MID = BAUD_CNT_END/2; the baud counter width is the minimum width that holds BAUD_CNT_END-1.
REQ-010 SHALL pass rs232_rx through two flip-flops for metastability, plus a third stage for edge detection; all three stages reset to 1.
REQ-011 SHALL implement states IDLE, START, DATA, STOP and ERR_WAIT; the reset state is IDLE.
REQ-012 IDLE -> START on a synchronized falling edge (stage 3 = 1, stage 2 = 0); the baud counter clears to 0 on that edge.
REQ-013 The baud counter SHALL count 0..BAUD_CNT_END-1 and then wrap to 0 while in START, DATA or STOP; it SHALL be held at 0 in IDLE and in ERR_WAIT.
REQ-014 START: when the counter equals BAUD_CNT_MID, a sampled line of 0 SHALL go to DATA with bit index 0; a sampled line of 1 is a glitch and SHALL return to IDLE with no output activity.
REQ-015 DATA: the line SHALL be sampled once per bit when the counter equals BAUD_CNT_MID and shifted into the shift register LSB-first; after bit index 7 is sampled, the block SHALL go to STOP; the bit index is 3 bits wide and resets to 0 on entry to DATA.
REQ-016 STOP, stop bit sampled high at BAUD_CNT_MID: the block SHALL register uart_data <= shift register, pulse uart_data_vld high for exactly 1 clk, and go to IDLE in the same cycle so that a following start edge can be detected within half a bit.
REQ-017 STOP, stop bit sampled low at BAUD_CNT_MID: the block SHALL pulse frame_err for 1 clk, leave uart_data and uart_data_vld unchanged, and go to ERR_WAIT.
REQ-018 ERR_WAIT SHALL go to IDLE only when the synchronized line is 1 (break tolerance); a falling edge seen on the cycle of entry to IDLE SHALL not be detected until the following cycle's edge logic.
REQ-019 Falling edges SHALL be ignored in every state other than IDLE.
REQ-020 uart_data_vld and frame_err SHALL be registered outputs, mutually exclusive, and never high for two consecutive cycles.
REQ-021 Latency: uart_data_vld SHALL rise 3 + 9*BAUD_CNT_END + BAUD_CNT_MID (+/-1) clk after the rs232_rx falling edge of the start bit.
REQ-022 The block SHALL have no back-pressure: the downstream command decoder consumes uart_data on the strobe cycle, and uart_data stays stable for at least 9 bit periods after each strobe.

Reset
REQ-023 While rst_n=0, the block SHALL hold uart_data_vld=0, frame_err=0, uart_data=8'h00, state=IDLE, counters=0, shift register=0, and synchronizers=1, regardless of clk.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release, the next falling edge on a line that has returned high SHALL begin a new frame normally.

Verification
REQ-025 Frame 0x55 at defaults -> exactly one uart_data_vld pulse, uart_data=0x55, frame_err=0, at the REQ-021 latency.
REQ-026 Frames 0xAA then 0x55 back-to-back with no idle gap -> two vld pulses, uart_data=0xAA then 0x55, both 1 clk wide.
REQ-027 Low glitch of 100 clk on an idle line, then frame 0x3C -> no strobe for the glitch; then vld with uart_data=0x3C.
REQ-028 Frame 0xFF with the stop bit driven low, line held low for 3 bit times, then high, then frame 0x12 -> one frame_err pulse, no vld, uart_data keeps its prior value; then vld with 0x12.
REQ-029 rst_n pulsed low during data bit 4 of frame 0x99, then frame 0xA5 -> no strobe for 0x99, outputs 0 during reset; then vld with uart_data=0xA5.
REQ-030 Parameter override CLK_FREQ=1_000_000, BAUD_RATE=115200 (BAUD_CNT_END=8), frame 0xC3 -> vld with uart_data=0xC3.
